// File: rtl/video_pkg.sv
// Shared types and defaults for the framebuffer reader: FSM states, FIFO word
// layout and the pixel-index to byte-address mapping.
package video_pkg;

  localparam int DEF_HDISP      = 800;
  localparam int DEF_VDISP      = 480;
  localparam int DEF_FIFO_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } pix_word_t;

  localparam int PIX_WORD_W = $bits(pix_word_t);

  // One 32-bit word per pixel, so the byte address advances by 4 per index.
  function automatic logic [31:0] pixAddr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read (rdata is the head word whenever not empty).
// Flush empties the FIFO and overrides any push or pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_wrEn;
  logic             w_rdEn;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (r_wrPtr == r_rdPtr);
  assign full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign level  = r_wrPtr - r_rdPtr;
  assign w_wrEn = push & ~full & ~flush;
  assign w_rdEn = pop & ~empty & ~flush;
  assign rdata  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone B4 classic read master that walks a linear framebuffer and streams
// the words, tagged with start-of-frame, through a show-ahead FIFO.
module wshb_frame_reader
  import video_pkg::*;
#(
  parameter int          HDISP      = DEF_HDISP,
  parameter int          VDISP      = DEF_VDISP,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        enable,
  input  logic                        restart,
  output logic                        wb_cyc,
  output logic                        wb_stb,
  output logic                        wb_we,
  output logic [31:0]                 wb_adr,
  output logic [3:0]                  wb_sel,
  output logic [2:0]                  wb_cti,
  output logic [1:0]                  wb_bte,
  output logic [31:0]                 wb_dat_ms,
  input  logic [31:0]                 wb_dat_sm,
  input  logic                        wb_ack,
  input  logic                        wb_err,
  input  logic                        wb_rty,
  output logic [31:0]                 pix_data,
  output logic                        pix_sof,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int NPIX = HDISP * VDISP;
  localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LVLW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPIX - 1);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(FIFO_DEPTH);

  rd_state_t       r_state;
  rd_state_t       w_stateNext;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idxNext;
  logic            r_restartPend;
  logic            w_restartPendNext;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic            w_term;
  logic            w_empty;
  logic            w_full;
  logic            w_room;
  logic [LVLW-1:0] w_level;
  logic [LVLW-1:0] w_levelAfter;
  pix_word_t       w_wrWord;
  pix_word_t       w_rdWord;

  assign w_term   = wb_ack | wb_err | wb_rty;
  assign w_pop    = ~w_empty & pix_ready;
  assign w_wrWord = '{sof: (r_idx == '0), data: wb_dat_sm};

  // A restart seen mid-transfer is parked until the slave terminates; the
  // terminating word is then dropped and the flush applied in its place.
  always_comb begin
    w_flush           = 1'b0;
    w_push            = 1'b0;
    w_idxNext         = r_idx;
    w_restartPendNext = r_restartPend;
    case (r_state)
      REQ: begin
        if (w_term) begin
          if (restart || r_restartPend) begin
            w_flush           = 1'b1;
            w_idxNext         = '0;
            w_restartPendNext = 1'b0;
          end else if (wb_ack) begin
            w_push    = 1'b1;
            w_idxNext = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          end
        end else if (restart) begin
          w_restartPendNext = 1'b1;
        end
      end
      default: begin
        if (restart) begin
          w_flush   = 1'b1;
          w_idxNext = '0;
        end
      end
    endcase
  end

  // Occupancy after this edge; requesting only while it is below depth means
  // an ack can never find the FIFO full.
  assign w_levelAfter = w_flush ? '0 : (w_level + LVLW'(w_push) - LVLW'(w_pop));
  assign w_room       = (w_levelAfter != FULL_LVL);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (enable && w_room) w_stateNext = REQ;
      end
      REQ: begin
        if (w_term) begin
          if (!enable)     w_stateNext = IDLE;
          else if (!w_room) w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (!enable)     w_stateNext = IDLE;
        else if (w_room) w_stateNext = REQ;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_restartPend <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_idx         <= w_idxNext;
      r_restartPend <= w_restartPendNext;
    end
  end

  sync_fifo #(
    .WIDTH (PIX_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flush     (w_flush),
    .push      (w_push),
    .wdata     (w_wrWord),
    .pop       (w_pop),
    .rdata     (w_rdWord),
    .empty     (w_empty),
    .full      (w_full),
    .level     (w_level)
  );

  // Strobe comes straight from the state register so reset drops it at once.
  assign wb_cyc    = (r_state == REQ);
  assign wb_stb    = (r_state == REQ);
  assign wb_we     = 1'b0;
  assign wb_adr    = pixAddr(BASE_ADDR, 32'(r_idx));
  assign wb_sel    = 4'hF;
  assign wb_cti    = 3'b000;
  assign wb_bte    = 2'b00;
  assign wb_dat_ms = 32'h0;

  assign pix_data   = w_rdWord.data;
  assign pix_sof    = w_rdWord.sof & ~w_empty;
  assign pix_valid  = ~w_empty;
  assign fifo_level = w_level;

endmodule
